npc_exec_datapath: RTL and testbench

- Execute-stage datapath for the single-cycle RV32 NPC core.
- Contains a 32-entry x 32-bit integer register file with 2 read ports and 1 write port, an integer ALU, and a 3-to-8 one-hot funct3 decoder.
- The core's control logic drives register addresses, write enable/data, ALU operand values and opcode. The block returns read data, the ALU result and the decoded funct3.

---
 rtl/npc_exec_datapath.sv | 186 ++++++++++++++++++
 tb/tb_npc_exec_datapath.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/npc_exec_datapath.sv
// Execute-stage datapath for the single-cycle RV32 NPC core: a 32x32 register file, an integer ALU and a one-hot funct3 decoder.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.

module npc_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [0:NREG-1];
    logic              wr_fire;

    // x0 is hardwired: its writes are dropped here and its reads are forced to 0 below.
    assign wr_fire = wen && (waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forwarding is gated by reset so the ports read 0 while the file is being cleared.
    assign fwd1 = reset && wr_fire && (raddr1 == waddr);
    assign fwd2 = reset && wr_fire && (raddr2 == waddr);

    always_comb begin
        rdata1 = '0;
        if (fwd1) begin
            rdata1 = wdata;
        end else if (raddr1 != '0) begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (fwd2) begin
            rdata2 = wdata;
        end else if (raddr2 != '0) begin
            rdata2 = regs[raddr2];
        end
    end
`else
    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = regs[raddr2];
        end
    end
`endif
endmodule

module npc_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_src1,
    input  logic [DATA_W-1:0] alu_src2,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_result
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic [SH_W-1:0] sh;
    logic            lt_signed;
    logic            lt_unsigned;

    assign sh          = alu_src2[SH_W-1:0];
    assign lt_signed   = $signed(alu_src1) < $signed(alu_src2);
    assign lt_unsigned = alu_src1 < alu_src2;

    // Unassigned opcodes 11..15 fall through to the zero default.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:   alu_result = alu_src1 + alu_src2;
            OP_SUB:   alu_result = alu_src1 - alu_src2;
            OP_SLL:   alu_result = alu_src1 << sh;
            OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
            OP_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
            OP_XOR:   alu_result = alu_src1 ^ alu_src2;
            OP_SRL:   alu_result = alu_src1 >> sh;
            OP_SRA:   alu_result = $unsigned($signed(alu_src1) >>> sh);
            OP_OR:    alu_result = alu_src1 | alu_src2;
            OP_AND:   alu_result = alu_src1 & alu_src2;
            OP_PASSB: alu_result = alu_src2;
            default:  alu_result = '0;
        endcase
    end
endmodule

module npc_funct3_dec (
    input  logic [2:0] funct3,
    output logic [7:0] funct3_d
);
    always_comb begin
        funct3_d = '0;
        funct3_d[funct3] = 1'b1;
    end
endmodule

module npc_exec_datapath #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] alu_src1,
    input  logic [DATA_W-1:0] alu_src2,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        funct3,
    output logic [7:0]        funct3_d
);
    npc_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    npc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    npc_funct3_dec u_dec (
        .funct3   (funct3),
        .funct3_d (funct3_d)
    );
endmodule

// File: tb/tb_npc_exec_datapath.sv
// Bench for npc_exec_datapath: directed corner cases plus randomized traffic against an array/arithmetic reference model.
module tb_npc_exec_datapath;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking_en = 0;

  logic [31:0] model_regs [32];

  npc_exec_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_d   (funct3_d)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference register file: plain array, async clear, writes only out of reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (wen && waddr != 5'd0) begin
      model_regs[waddr] = wdata;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : model_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (reset && wen && waddr != 5'd0 && a == waddr) v = wdata;
`endif
    return v;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b) + 32'd1;
      4'd2:  return a * (32'd1 << sh);
      4'd3:  return ((a[31] && !b[31]) || (a[31] == b[31] && a < b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'd1 << sh);
      4'd7:  return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking_en) begin
      check("cmp_rdata1", rdata1, model_read(raddr1));
      check("cmp_rdata2", rdata2, model_read(raddr2));
      check("cmp_alu", alu_result, model_alu(alu_op, alu_src1, alu_src2));
      check("cmp_dec", {24'h0, funct3_d}, {24'h0, 8'd1 << funct3});
    end
  end

  // drivers
  task automatic drive_idle();
    wen = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
    alu_src1 = 0; alu_src2 = 0; alu_op = 0; funct3 = 0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wen = 1; waddr = a; wdata = d;
    @(posedge clk); #1;
    wen = 0;
  endtask

  task automatic alu_case(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    alu_op = op; alu_src1 = a; alu_src2 = b;
    #1 check(name, alu_result, exp);
  endtask

  task automatic reset_pulse();
    logic [4:0] blk;
    checking_en = 0;
    @(posedge clk); #1;
    blk = 5'($urandom_range(1, 31));
    wen = 1; waddr = blk; wdata = $urandom() | 32'h1;
    #1 reset = 0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check("rst_rdata1", rdata1, 32'h0);
      check("rst_rdata2", rdata2, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1; wen = 0; raddr1 = blk;
    #1 check("rst_write_blocked", rdata1, 32'h0);
    checking_en = 1;
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      wen    = $urandom_range(0, 1);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom();
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      alu_op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: alu_src1 = 32'h8000_0000;
        1: alu_src1 = 32'hFFFF_FFFF;
        default: alu_src1 = $urandom();
      endcase
      alu_src2 = ($urandom_range(0, 4) == 0) ? alu_src1 : $urandom();
      funct3   = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    reset = 0;
    drive_idle();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    #2;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    check("reset_dec", {24'h0, funct3_d}, 32'h01);
    @(posedge clk); #1;
    reset = 1;
    checking_en = 1;

    write_reg(5'd5, 32'hDEADBEEF);
    raddr1 = 5; raddr2 = 5;
    #1;
    check("x5_port1", rdata1, 32'hDEADBEEF);
    check("x5_port2", rdata2, 32'hDEADBEEF);
    write_reg(5'd0, 32'h12345678);
    raddr1 = 0;
    #1 check("x0_zero", rdata1, 32'h0);

    write_reg(5'd7, 32'h1);
    wen = 1; waddr = 7; raddr1 = 7; wdata = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", rdata1, 32'hA5A5A5A5);
`else
    check("rdw_before_edge", rdata1, 32'h1);
`endif
    @(posedge clk); #1;
    wen = 0;
    #1 check("rdw_after_edge", rdata1, 32'hA5A5A5A5);

    alu_case("add_wrap", 4'd0,  32'hFFFFFFFF, 32'h1, 32'h0);
    alu_case("sub_wrap", 4'd1,  32'h0, 32'h1, 32'hFFFFFFFF);
    alu_case("slt",      4'd3,  32'hFFFFFFFF, 32'h1, 32'h1);
    alu_case("sltu",     4'd4,  32'hFFFFFFFF, 32'h1, 32'h0);
    alu_case("op13",     4'd13, 32'h1234, 32'h5678, 32'h0);
    alu_case("sra",      4'd7,  32'h80000000, 32'h24, 32'hF8000000);
    alu_case("srl",      4'd6,  32'h80000000, 32'h4, 32'h08000000);
    alu_case("sll",      4'd2,  32'h1, 32'h1F, 32'h80000000);
    alu_case("and",      4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu_case("or",       4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    alu_case("xor",      4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    alu_case("passb",    4'd10, 32'hFFFFFFFF, 32'h12345000, 32'h12345000);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      funct3 = 3'(i);
      #1;
      check("dec_value", {24'h0, funct3_d}, 32'h1 << i);
      check("dec_onehot", $countones(funct3_d), 32'd1);
    end

    for (int r = 0; r < 4; r++) begin
      random_cycles(600);
      reset_pulse();
    end
    random_cycles(300);

    @(posedge clk); #1;
    checking_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
